// File: rtl/wb_arbiter.sv
// wb_arbiter: owns the register file's single write port and merges two sources.
//   The in-order pipeline (pipe_*) always wins the port and never backpressures.
//   Mul/div results (md_*) arrive over a valid/ready handshake into a small FIFO.
//   A pipeline write kills any queued mul/div write to the same register, so the
//   newer value survives.
// Ports:
//   clk, rst                       clock, synchronous active-low reset
//   pipe_we/pipe_waddr/pipe_wdata  pipeline write-back request
//   md_valid/md_waddr/md_wdata     mul/div result offer; md_ready accepts it (comb)
//   raddr1/raddr2 -> pend1/pend2   decode hazard query against live FIFO entries (comb)
//   stall_req                      registered request to withhold pipe_we (starvation)
//   we/waddr/wdata                 registered register-file write port
module wb_arbiter #(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_waddr,
  input  logic [31:0] pipe_wdata,
  input  logic        md_valid,
  input  logic [4:0]  md_waddr,
  input  logic [31:0] md_wdata,
  output logic        md_ready,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic        pend1,
  output logic        pend2,
  output logic        stall_req,
  output logic        we,
  output logic [4:0]  waddr,
  output logic [31:0] wdata
);

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = 4;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

  // FIFO storage and bookkeeping
  logic [DEPTH-1:0] r_live;
  logic [AW-1:0]    r_addr [DEPTH];
  logic [DW-1:0]    r_data [DEPTH];
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic [SW-1:0]    r_starve;

  // Registered outputs
  logic             r_we;
  logic [AW-1:0]    r_waddr;
  logic [DW-1:0]    r_wdata;
  logic             r_stall;

  // Combinational decode
  logic             w_pipe_eff;
  logic             w_head_valid;
  logic             w_head_live;
  logic             w_live_pop;
  logic             w_dead_pop;
  logic             w_pop;
  logic             w_push;
  logic             w_push_live;
  logic [CW-1:0]    w_count_nxt;
  logic [SW-1:0]    w_starve_nxt;
  logic             w_hit1;
  logic             w_hit2;

  // Port arbitration: pipeline first, then a live head; a dead head is always dropped
  always_comb begin
    w_pipe_eff   = pipe_we && (pipe_waddr != '0);
    w_head_valid = (r_count != '0);
    w_head_live  = w_head_valid && r_live[r_rd_ptr];
    w_live_pop   = w_head_live && !w_pipe_eff;
    w_dead_pop   = w_head_valid && !r_live[r_rd_ptr];
    w_pop        = w_live_pop || w_dead_pop;
    md_ready     = (r_count < DEPTH_C) && rst;
    w_push       = md_valid && md_ready;
    // An x0 result, or one overtaken by a same-cycle pipeline write, enters dead
    w_push_live  = (md_waddr != '0) && !(w_pipe_eff && (md_waddr == pipe_waddr));
    w_count_nxt  = r_count + CW'(w_push) - CW'(w_pop);
  end

  // Starvation counter next value: clear wins over increment
  always_comb begin
    w_starve_nxt = r_starve;
    if (w_live_pop || (w_count_nxt == '0)) begin
      w_starve_nxt = '0;
    end else if (w_head_live && w_pipe_eff && (r_starve < LIMIT_C)) begin
      w_starve_nxt = r_starve + SW'(1);
    end
  end

  // Hazard lookup over live entries only (dead/empty slots never have live set)
  always_comb begin
    w_hit1 = 1'b0;
    w_hit2 = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (r_live[i] && (r_addr[i] == raddr1)) w_hit1 = 1'b1;
      if (r_live[i] && (r_addr[i] == raddr2)) w_hit2 = 1'b1;
    end
    pend1 = rst && (raddr1 != '0) && w_hit1;
    pend2 = rst && (raddr2 != '0) && w_hit2;
  end

  // FIFO state; later assignments to r_live override earlier ones on the same slot
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_live   <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_pipe_eff) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (r_addr[i] == pipe_waddr) r_live[i] <= 1'b0;
        end
      end
      if (w_pop) begin
        r_live[r_rd_ptr] <= 1'b0;
        r_rd_ptr         <= r_rd_ptr + PW'(1);
      end
      // Push never targets the head slot: push needs count<DEPTH, pop needs count>0
      if (w_push) begin
        r_live[r_wr_ptr] <= w_push_live;
        r_addr[r_wr_ptr] <= md_waddr;
        r_data[r_wr_ptr] <= md_wdata;
        r_wr_ptr         <= r_wr_ptr + PW'(1);
      end
      r_count <= w_count_nxt;
    end
  end

  // Write port, starvation counter and stall request
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_we     <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
      r_starve <= '0;
      r_stall  <= 1'b0;
    end else begin
      if (w_pipe_eff) begin
        r_we    <= 1'b1;
        r_waddr <= pipe_waddr;
        r_wdata <= pipe_wdata;
      end else if (w_live_pop) begin
        r_we    <= 1'b1;
        r_waddr <= r_addr[r_rd_ptr];
        r_wdata <= r_data[r_rd_ptr];
      end else begin
        r_we    <= 1'b0;
      end
      r_starve <= w_starve_nxt;
      r_stall  <= (w_starve_nxt == LIMIT_C);
    end
  end

  assign we        = r_we;
  assign waddr     = r_waddr;
  assign wdata     = r_wdata;
  assign stall_req = r_stall;

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        md_valid;
  logic [4:0]  md_waddr;
  logic [31:0] md_wdata;
  logic        md_ready;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic        pend1;
  logic        pend2;
  logic        stall_req;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  always #5 clk = ~clk;

  wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
    .md_valid(md_valid), .md_waddr(md_waddr), .md_wdata(md_wdata), .md_ready(md_ready),
    .raddr1(raddr1), .raddr2(raddr2), .pend1(pend1), .pend2(pend2),
    .stall_req(stall_req), .we(we), .waddr(waddr), .wdata(wdata)
  );

  // Reference model: an ordered list of pending results plus the port registers
  typedef struct {
    bit          live;
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  logic        m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  int          m_starve;
  logic        m_stall;
  bit          m_acc;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_pend(input logic [4:0] ra);
    if (!rst || ra == 5'd0) return 1'b0;
    foreach (q[i]) if (q[i].live && q[i].a == ra) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_all();
    chk("md_ready", md_ready, (rst && q.size() < DEPTH) ? 1 : 0);
    chk("pend1", pend1, model_pend(raddr1));
    chk("pend2", pend2, model_pend(raddr2));
    chk("stall_req", stall_req, m_stall);
    chk("we", we, m_we);
    chk("waddr", waddr, m_waddr);
    chk("wdata", wdata, m_wdata);
  endtask

  task automatic model_step();
    bit   pe, hv, hl, lp;
    ent_t e;
    if (!rst) begin
      q.delete();
      m_we = 0; m_waddr = '0; m_wdata = '0;
      m_starve = 0; m_stall = 0; m_acc = 0;
      return;
    end
    pe = pipe_we && (pipe_waddr != 0);
    hv = q.size() > 0;
    hl = hv && q[0].live;
    m_acc = md_valid && (q.size() < DEPTH);
    if (pe) begin
      m_we = 1; m_waddr = pipe_waddr; m_wdata = pipe_wdata;
    end else if (hl) begin
      m_we = 1; m_waddr = q[0].a; m_wdata = q[0].d;
    end else begin
      m_we = 0;
    end
    lp = hl && !pe;
    if (hl && pe && m_starve < LIMIT) m_starve++;
    if (hv && (!hl || lp)) void'(q.pop_front());
    if (pe) foreach (q[i]) if (q[i].a == pipe_waddr) q[i].live = 0;
    if (m_acc) begin
      e.live = (md_waddr != 0) && !(pe && md_waddr == pipe_waddr);
      e.a = md_waddr;
      e.d = md_wdata;
      q.push_back(e);
    end
    if (lp || q.size() == 0) m_starve = 0;
    m_stall = (m_starve == LIMIT);
  endtask

  // One cycle: check mid-cycle, advance model, pass the edge
  task automatic tick();
    @(negedge clk);
    check_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pipe_we = 0; pipe_waddr = '0; pipe_wdata = '0;
    md_valid = 0; md_waddr = '0; md_wdata = '0;
  endtask

  initial begin
    rst = 0; raddr1 = '0; raddr2 = '0;
    idle_inputs();
    model_step();
    @(posedge clk); #1;
    tick();
    rst = 1;

    // Single mul/div result, idle pipeline
    raddr1 = 5'd5;
    md_valid = 1; md_waddr = 5'd5; md_wdata = 32'h1234;
    tick();
    idle_inputs(); #1;
    chk("x5_pend_t1", pend1, 1'b1);
    tick();
    chk("x5_we_t2", we, 1'b1);
    chk("x5_waddr_t2", waddr, 5'd5);
    chk("x5_wdata_t2", wdata, 32'h1234);
    chk("x5_pend_t2", pend1, 1'b0);
    tick();

    // Same-cycle conflict: pipe first, md one cycle later
    pipe_we = 1; pipe_waddr = 5'd3; pipe_wdata = 32'hA;
    md_valid = 1; md_waddr = 5'd7; md_wdata = 32'hB;
    tick();
    idle_inputs();
    chk("conf_waddr_t1", waddr, 5'd3);
    tick();
    chk("conf_we_t2", we, 1'b1);
    chk("conf_waddr_t2", waddr, 5'd7);
    chk("conf_wdata_t2", wdata, 32'hB);
    tick();

    // Kill: queued x9 overtaken by pipeline write to x9
    raddr1 = 5'd9;
    md_valid = 1; md_waddr = 5'd9; md_wdata = 32'h99;
    tick();
    idle_inputs();
    pipe_we = 1; pipe_waddr = 5'd9; pipe_wdata = 32'h55; #1;
    chk("kill_pend_before", pend1, 1'b1);
    tick();
    idle_inputs(); #1;
    chk("kill_wdata", wdata, 32'h55);
    chk("kill_pend_after", pend1, 1'b0);
    tick();
    chk("kill_no_second_we", we, 1'b0);
    tick();

    // x0 handling
    md_valid = 1; md_waddr = 5'd4; md_wdata = 32'h44;
    tick();
    idle_inputs();
    pipe_we = 1; pipe_waddr = 5'd0; pipe_wdata = 32'hDEAD;
    tick();
    idle_inputs();
    chk("x0_head_we", we, 1'b1);
    chk("x0_head_waddr", waddr, 5'd4);
    md_valid = 1; md_waddr = 5'd0; md_wdata = 32'h77;
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("x0_md_no_we", we, 1'b0);
    end

    // Backpressure and starvation
    begin
      int k = 0;
      logic [4:0] mda [3] = '{5'd20, 5'd21, 5'd22};
      for (int c = 0; c < 7; c++) begin
        pipe_we = 1; pipe_waddr = 5'($urandom_range(15, 1)); pipe_wdata = $urandom;
        md_valid = (k < 3); md_waddr = mda[k < 3 ? k : 2]; md_wdata = 32'h100 + 32'(k);
        tick();
        if (m_acc) k++;
      end
      #1;
      chk("bp_accepts", 32'(k), 32'd2);
      chk("bp_ready_low", md_ready, 1'b0);
      chk("bp_stall", stall_req, 1'b1);
      idle_inputs();
      tick();
      chk("bp_drain1_addr", waddr, 5'd20);
      chk("bp_stall_clear", stall_req, 1'b0);
      tick();
      chk("bp_drain2_addr", waddr, 5'd21);
      tick();
    end

    // Reset with a full FIFO discards everything
    raddr1 = 5'd12;
    pipe_we = 1; pipe_waddr = 5'd1; pipe_wdata = 32'h1;
    md_valid = 1; md_waddr = 5'd12; md_wdata = 32'hC;
    tick();
    md_waddr = 5'd13; md_wdata = 32'hD;
    tick();
    md_valid = 0; #1;
    chk("rst_full_pend", pend1, 1'b1);
    rst = 0;
    tick();
    rst = 1;
    idle_inputs(); #1;
    chk("rst_we", we, 1'b0);
    chk("rst_ready", md_ready, 1'b1);
    chk("rst_pend", pend1, 1'b0);
    tick();
    tick();

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      rst        = ($urandom_range(60, 0) != 0);
      pipe_we    = ($urandom_range(1, 0) == 1);
      pipe_waddr = 5'($urandom_range(7, 0));
      pipe_wdata = $urandom;
      md_valid   = ($urandom_range(2, 0) != 0);
      md_waddr   = 5'($urandom_range(7, 0));
      md_wdata   = $urandom;
      raddr1     = 5'($urandom_range(7, 0));
      raddr2     = 5'($urandom_range(7, 0));
      tick();
    end
    rst = 1;
    idle_inputs();
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter that owns the register file's single write port (`we`/`waddr`/`wdata`). It merges two result sources: the in-order ALU/MEM pipeline, which always has priority and never backpressures, and a multi-cycle mul/div unit, which hands results over a valid/ready handshake into a small FIFO. The block kills stale mul/div writes that a newer pipeline write has overtaken. It reports pending-write hazards back to decode and raises a stall request when the FIFO is starved.

## Interface
Parameters:
- `DEPTH`, 2: mul/div result FIFO entries (power of two, ≥2).
- `STARVE_LIMIT`, 4: consecutive blocked cycles before `stall_req` asserts (1..15).

Ports:
- `clk`  in  1  sole clock, all state updates on posedge.
- `rst`  in  1  synchronous reset, active-low: state resets at a posedge where `rst`==0.
- `pipe_we`  in  1  pipeline write-back valid.
- `pipe_waddr`  in  5  pipeline destination register.
- `pipe_wdata`  in  32  pipeline result.
- `md_valid`  in  1  mul/div result valid.
- `md_waddr`  in  5  mul/div destination.
- `md_wdata`  in  32  mul/div result.
- `md_ready`  out  1  FIFO can accept this cycle.
- `raddr1`, `raddr2`  in  5  decode read addresses.
- `pend1`, `pend2`  out  1  a live FIFO entry targets `raddr1`/`raddr2`.
- `stall_req`  out  1  request that the pipeline withhold `pipe_we`.
- `we`  out  1  register file write enable.
- `waddr`  out  5  register file write address.
- `wdata`  out  32  register file write data.

## Operation
- A pipeline write is effective when `pipe_we`=1 and `pipe_waddr`≠0. A write to x0 is a no-op and leaves the port free.
- FIFO entry fields: live bit, waddr, wdata.
- Enqueue when `md_valid`&&`md_ready`. `md_ready` = (count<DEPTH) && `rst`=1. It is combinational and does not credit a same-cycle pop.
- A `md_waddr`=0 result is enqueued dead (live=0).
- Port select each cycle, by priority:
  1. An effective pipeline write takes the port.
  2. Otherwise, a live FIFO head takes the port and is popped.
  3. Otherwise the port is idle.
- A dead head is always popped in the cycle it is at the head, without using the port. This happens even while the pipeline takes the port.
- The selection is registered into `we`/`waddr`/`wdata`. When idle, `we`=0 and `waddr`/`wdata` hold their previous values.
- Kill rule (newer-wins ordering):
  - An effective pipeline write to address r clears the live bit of every FIFO entry with waddr=r at the same edge.
  - An entry being enqueued in that cycle with `md_waddr`=r is also enqueued dead.
- `pend1` = `raddr1`≠0 && any live entry has waddr=`raddr1`. `pend2` is the same for `raddr2`. Both are combinational on current FIFO contents only; the same-cycle incoming `md_*` is excluded.
- Starvation counter (4 bits):
  - Increments each cycle a live head exists and the pipeline takes the port.
  - Clears on any live pop, or when the FIFO empties.
  - Saturates at STARVE_LIMIT.
- `stall_req` is registered: it is 1 in the cycle after the counter reaches STARVE_LIMIT, and drops in the cycle after the live pop.
- Pipeline priority is absolute. If `pipe_we` is presented while `stall_req`=1, the pipeline still wins.
- Simultaneous enqueue and pop in the same cycle: count is unchanged and pointers advance correctly. When full with a pop, `md_ready` is still 0.

## Timing
- Pipeline input at cycle t appears on `we`/`waddr`/`wdata` at t+1. The register file commits at the t+1 edge, and its bypass covers reads during t+1.
- Mul/div latency is at least 2 cycles: enqueue at the end of t, earliest head select in t+1, `we` in t+2.
- Pointers wrap modulo DEPTH.
- Reset values: `we`=0, `waddr`=0, `wdata`=0, `stall_req`=0, FIFO empty, counter 0. `md_ready`=0 and `pend1`=`pend2`=0 while `rst`=0.
- Reset mid-operation discards all queued results; no write is issued for them.

## Test plan
- Reset with a full FIFO: `rst`=0 for 1 edge → next cycle `we`=0, `md_ready`=1, `pend1`=0 for the previously queued address.
- Idle pipeline, `md_valid` with x5=0x1234 at t → `we`=1, `waddr`=5, `wdata`=0x1234 at t+2. `pend1`(raddr1=5)=1 only during t+1.
- Conflict: pipe writes x3=0xA and `md_valid` x7=0xB in the same cycle, pipe idle after → x3 written at t+1, x7 at t+2, never in the same cycle.
- Kill: x9 queued, then pipe writes x9=0x55 → only 0x55 reaches `waddr`=9. The dead entry pops with no second write, and `pend1`(9) drops the cycle after the kill.
- Backpressure: DEPTH=2, pipe writes every cycle with nonzero addresses, 3 md results offered → `md_ready`=0 after 2 accepts. `stall_req`=1 after 4 blocked cycles. Dropping `pipe_we` drains the FIFO in order and `stall_req` clears the cycle after the first pop.
- x0 handling: pipe writes x0 while a live head exists → the head is written that cycle. An md result to x0 never asserts `we`.
